// File: rtl/f_to_d_queue_pkg.sv
// Shared fetch/decode definitions: NOP encoding and fetch-bundle sizing.
package pipe_pkg;

  localparam int          DEF_XLEN    = 32;
  localparam int          DEF_PC_BITS = 12;
  localparam logic [31:0] NOP_INST    = 32'h2000_0000;

  // One queued fetch bundle: pc, inst, taken flag, target pc, link address.
  function automatic int fetch_bundle_w(input int pc_bits, input int xlen);
    return 2 * pc_bits + 2 * xlen + 1;
  endfunction

  localparam int FETCH_BUNDLE_W = fetch_bundle_w(DEF_PC_BITS, DEF_XLEN);

endpackage

// File: rtl/f_to_d_queue_if.sv
// Fetch-to-decode queue handshake bundle.
// master: fetch/decode side driving F_* and D_ready; slave: the queue itself.
interface f_to_d_queue_if
  import pipe_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int PC_BITS = DEF_PC_BITS,
  parameter int DEPTH   = 4
);

  logic                       F_valid;
  logic                       F_ready;
  logic [PC_BITS-1:0]         F_pc;
  logic [XLEN-1:0]            F_inst;
  logic                       F_BP_taken;
  logic [PC_BITS-1:0]         F_BP_target_pc;
  logic [XLEN-1:0]            F_link_addr;
  logic                       flush;
  logic                       D_ready;
  logic                       D_valid;
  logic [PC_BITS-1:0]         D_pc;
  logic [XLEN-1:0]            D_inst;
  logic                       D_BP_taken;
  logic [PC_BITS-1:0]         D_BP_target_pc;
  logic [XLEN-1:0]            D_link_addr;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output F_valid, F_pc, F_inst, F_BP_taken, F_BP_target_pc, F_link_addr,
    output flush, D_ready,
    input  F_ready, D_valid, D_pc, D_inst, D_BP_taken, D_BP_target_pc, D_link_addr,
    input  count
  );

  modport slave (
    input  F_valid, F_pc, F_inst, F_BP_taken, F_BP_target_pc, F_link_addr,
    input  flush, D_ready,
    output F_ready, D_valid, D_pc, D_inst, D_BP_taken, D_BP_target_pc, D_link_addr,
    output count
  );

endinterface

// File: rtl/f_to_d_queue_storage.sv
// Fetch-bundle register array: one synchronous write port, one async read port.
// Deliberately unreset; validity is tracked by the queue's count.
module fq_storage #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the pushed bundle into its slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/f_to_d_queue.sv
// Fetch-to-decode instruction queue: circular buffer with valid/ready on both
// sides, no fall-through, flush and reset clear pointers and occupancy only.
module f_to_d_queue
  import pipe_pkg::*;
#(
  parameter int              XLEN    = DEF_XLEN,
  parameter int              PC_BITS = DEF_PC_BITS,
  parameter int              DEPTH   = 4,
  parameter logic [XLEN-1:0] NOP     = XLEN'(NOP_INST)
) (
  input logic          clk,
  input logic          rst,
  f_to_d_queue_if.slave q
);

  localparam int              PTR_W = $clog2(DEPTH);
  localparam int              CNT_W = $clog2(DEPTH + 1);
  localparam int              BW    = fetch_bundle_w(PC_BITS, XLEN);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_r;
  logic             push;
  logic             pop;
  logic [BW-1:0]    wr_bundle;
  logic [BW-1:0]    rd_bundle;

  // Ready/valid come from registered occupancy only, so a full queue never
  // accepts even when the head leaves in the same cycle.
  assign q.F_ready = (count_r != FULL);
  assign q.D_valid = (count_r != '0);
  assign q.count   = count_r;

  assign push = q.F_valid & q.F_ready & ~q.flush;
  assign pop  = q.D_valid & q.D_ready & ~q.flush;

  assign wr_bundle = {q.F_pc, q.F_inst, q.F_BP_taken, q.F_BP_target_pc, q.F_link_addr};

  fq_storage #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_bundle),
    .raddr (rd_ptr),
    .rdata (rd_bundle)
  );

  // Pointer and occupancy update; reset outranks flush, flush outranks traffic.
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Present the head bundle, or a NOP with zeroed side fields when empty.
  always_comb begin
    q.D_pc           = '0;
    q.D_inst         = NOP;
    q.D_BP_taken     = 1'b0;
    q.D_BP_target_pc = '0;
    q.D_link_addr    = '0;
    if (q.D_valid) begin
      {q.D_pc, q.D_inst, q.D_BP_taken, q.D_BP_target_pc, q.D_link_addr} = rd_bundle;
    end
  end

endmodule

// File: tb/tb_f_to_d_queue.sv
// Directed table-driven bench for the fetch-to-decode queue.
module tb_f_to_d_queue;

  localparam int XLEN    = 32;
  localparam int PC_BITS = 12;
  localparam int DEPTH   = 4;
  localparam logic [31:0] NOP_VAL = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst;

  f_to_d_queue_if #(.XLEN(XLEN), .PC_BITS(PC_BITS), .DEPTH(DEPTH)) qif ();

  f_to_d_queue #(.XLEN(XLEN), .PC_BITS(PC_BITS), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               rst;
    logic               flush;
    logic               fv;
    logic               dr;
    logic [PC_BITS-1:0] pc;
    int                 cnt;
    logic               dv;
    logic               fr;
    logic [PC_BITS-1:0] hpc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Field values attached to each PC so every field can be traced end to end.
  function automatic logic [XLEN-1:0] inst_of(input logic [PC_BITS-1:0] pc);
    return 32'hA500_0000 | {20'h0, pc};
  endfunction
  function automatic logic tkn_of(input logic [PC_BITS-1:0] pc);
    return pc[3];
  endfunction
  function automatic logic [PC_BITS-1:0] tgt_of(input logic [PC_BITS-1:0] pc);
    return pc ^ 12'hFFF;
  endfunction
  function automatic logic [XLEN-1:0] link_of(input logic [PC_BITS-1:0] pc);
    return {20'h0, pc} + 32'd4;
  endfunction

  function automatic void add(input logic r, input logic fl, input logic fv, input logic dr,
                              input logic [PC_BITS-1:0] pc, input int cnt, input logic dv,
                              input logic fr, input logic [PC_BITS-1:0] hpc);
    vec_t v;
    v.rst = r; v.flush = fl; v.fv = fv; v.dr = dr; v.pc = pc;
    v.cnt = cnt; v.dv = dv; v.fr = fr; v.hpc = hpc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic dv, input logic [PC_BITS-1:0] hpc);
    check({tag, " D_valid"}, 64'(qif.D_valid), 64'(dv));
    if (dv) begin
      check({tag, " D_pc"},      64'(qif.D_pc),           64'(hpc));
      check({tag, " D_inst"},    64'(qif.D_inst),         64'(inst_of(hpc)));
      check({tag, " D_taken"},   64'(qif.D_BP_taken),     64'(tkn_of(hpc)));
      check({tag, " D_target"},  64'(qif.D_BP_target_pc), 64'(tgt_of(hpc)));
      check({tag, " D_link"},    64'(qif.D_link_addr),    64'(link_of(hpc)));
    end else begin
      check({tag, " D_pc"},      64'(qif.D_pc),           64'(0));
      check({tag, " D_inst"},    64'(qif.D_inst),         64'(NOP_VAL));
      check({tag, " D_taken"},   64'(qif.D_BP_taken),     64'(0));
      check({tag, " D_target"},  64'(qif.D_BP_target_pc), 64'(0));
      check({tag, " D_link"},    64'(qif.D_link_addr),    64'(0));
    end
  endtask

  task automatic drive(input logic r, input logic fl, input logic fv, input logic dr,
                       input logic [PC_BITS-1:0] pc);
    rst                = r;
    qif.flush          = fl;
    qif.F_valid        = fv;
    qif.D_ready        = dr;
    qif.F_pc           = pc;
    qif.F_inst         = inst_of(pc);
    qif.F_BP_taken     = tkn_of(pc);
    qif.F_BP_target_pc = tgt_of(pc);
    qif.F_link_addr    = link_of(pc);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);

    // reset
    add(1, 0, 0, 0, 12'h000, 0, 0, 1, 12'h000);
    // fill with D_ready low
    add(0, 0, 1, 0, 12'h000, 1, 1, 1, 12'h000);
    add(0, 0, 1, 0, 12'h004, 2, 1, 1, 12'h000);
    add(0, 0, 1, 0, 12'h008, 3, 1, 1, 12'h000);
    add(0, 0, 1, 0, 12'h00C, 4, 1, 0, 12'h000);
    // offer while full, nothing stored
    add(0, 0, 1, 0, 12'h010, 4, 1, 0, 12'h000);
    // drain in order
    add(0, 0, 0, 1, 12'h000, 3, 1, 1, 12'h004);
    add(0, 0, 0, 1, 12'h000, 2, 1, 1, 12'h008);
    add(0, 0, 0, 1, 12'h000, 1, 1, 1, 12'h00C);
    add(0, 0, 0, 1, 12'h000, 0, 0, 1, 12'h000);
    // empty with D_ready high
    add(0, 0, 0, 1, 12'h000, 0, 0, 1, 12'h000);
    // refill, then full with push and pop offered together
    add(0, 0, 1, 0, 12'h020, 1, 1, 1, 12'h020);
    add(0, 0, 1, 0, 12'h024, 2, 1, 1, 12'h020);
    add(0, 0, 1, 0, 12'h028, 3, 1, 1, 12'h020);
    add(0, 0, 1, 0, 12'h02C, 4, 1, 0, 12'h020);
    add(0, 0, 1, 1, 12'h030, 3, 1, 1, 12'h024);
    add(0, 0, 0, 1, 12'h000, 2, 1, 1, 12'h028);
    add(0, 0, 0, 1, 12'h000, 1, 1, 1, 12'h02C);
    add(0, 0, 0, 1, 12'h000, 0, 0, 1, 12'h000);
    // steady push+pop at count 2 across pointer wrap
    add(0, 0, 1, 0, 12'h040, 1, 1, 1, 12'h040);
    add(0, 0, 1, 0, 12'h044, 2, 1, 1, 12'h040);
    for (int k = 0; k < 10; k++)
      add(0, 0, 1, 1, 12'(12'h048 + 4 * k), 2, 1, 1, 12'(12'h044 + 4 * k));
    // flush at count 3 with a push offered
    add(0, 0, 1, 0, 12'h070, 3, 1, 1, 12'h068);
    add(0, 1, 1, 1, 12'h074, 0, 0, 1, 12'h000);
    add(0, 0, 0, 0, 12'h000, 0, 0, 1, 12'h000);
    add(0, 0, 1, 0, 12'h080, 1, 1, 1, 12'h080);
    // reset beats flush and push
    add(0, 0, 1, 0, 12'h084, 2, 1, 1, 12'h080);
    add(1, 1, 1, 1, 12'h088, 0, 0, 1, 12'h000);
    add(0, 0, 1, 0, 12'h08C, 1, 1, 1, 12'h08C);
    add(0, 0, 0, 1, 12'h000, 0, 0, 1, 12'h000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].flush, vecs[i].fv, vecs[i].dr, vecs[i].pc);
      #1;
      // Before the edge, handshake outputs must still reflect the old state.
      if (i > 0) begin
        check($sformatf("v%0d pre F_ready", i), 64'(qif.F_ready), 64'(vecs[i-1].fr));
        check($sformatf("v%0d pre D_valid", i), 64'(qif.D_valid), 64'(vecs[i-1].dv));
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d count", i),   64'(qif.count),   64'(vecs[i].cnt));
      check($sformatf("v%0d F_ready", i), 64'(qif.F_ready), 64'(vecs[i].fr));
      check_head($sformatf("v%0d", i), vecs[i].dv, vecs[i].hpc);
    end

    // No fall-through: an entry offered to an empty queue is not visible yet.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 12'h0A0);
    #1;
    check("fallthru D_valid", 64'(qif.D_valid), 64'(0));
    check("fallthru D_inst",  64'(qif.D_inst),  64'(NOP_VAL));
    @(posedge clk);
    #1;
    check_head("fallthru post", 1'b1, 12'h0A0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    @(posedge clk);
    #1;
    check("final count", 64'(qif.count), 64'(0));
    check_head("final", 1'b0, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
